pal_check_scheduler: RTL and testbench

PAL_CHECK_SCHEDULER -- requirements
Module: pal_check_scheduler

---
 rtl/pal_pkg.sv | 15 +
 rtl/palindrome_checker.sv | 19 +
 rtl/pal_check_scheduler.sv | 140 ++++++++++++++
 tb/tb_pal_check_scheduler.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pal_pkg.sv
// rtl/pal_pkg.sv - shared FSM states and index-width helper for the palindrome check scheduler
package pal_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_RESULT = 2'd2
    } state_e;

    // Width of a requester index; a single bit is kept even for tiny N.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/palindrome_checker.sv
// rtl/palindrome_checker.sv - combinational bit-mirror comparison of one data word
module palindrome_checker #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data_in,
    output logic             is_palindrome
);

    // A word is a palindrome when every bit matches its mirror position.
    always_comb begin
        is_palindrome = 1'b1;
        for (int k = 0; k < WIDTH / 2; k++) begin
            if (data_in[k] != data_in[WIDTH-1-k]) begin
                is_palindrome = 1'b0;
            end
        end
    end

endmodule

// File: rtl/pal_check_scheduler.sv
// rtl/pal_check_scheduler.sv - round-robin scheduler feeding a shared palindrome checker
module pal_check_scheduler
    import pal_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*WIDTH-1:0]        req_data,
    output logic [N_REQ-1:0]              req_ready,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [idx_w(N_REQ)-1:0]       res_id,
    output logic [WIDTH-1:0]              res_data,
    output logic                          res_palindrome,
    input  logic                          clear_counts,
    output logic [CNT_W-1:0]              total_count,
    output logic [CNT_W-1:0]              pal_count
);

    localparam int ID_W = idx_w(N_REQ);

    state_e            state_q;
    logic [ID_W-1:0]   rr_ptr_q;
    logic [ID_W-1:0]   res_id_q;
    logic [WIDTH-1:0]  res_data_q;
    logic              res_pal_q;
    logic              res_valid_q;
    logic [CNT_W-1:0]  total_q;
    logic [CNT_W-1:0]  pal_q;

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [WIDTH-1:0]  grant_word;
    logic              transfer;
    logic              res_hs;
    logic              check_pal;

    // Round-robin search upward from rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        int cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_word  = '0;
        cand        = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(cand);
                grant_word  = req_data[cand*WIDTH +: WIDTH];
            end
        end
    end

    // Ready is offered only in IDLE and only to the winner, so it follows valid combinationally.
    always_comb begin
        req_ready = '0;
        if (state_q == ST_IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign transfer = |(req_valid & req_ready);
    assign res_hs   = res_valid_q && res_ready;

    palindrome_checker #(
        .WIDTH (WIDTH)
    ) u_checker (
        .data_in       (res_data_q),
        .is_palindrome (check_pal)
    );

    // Scheduler FSM: capture on transfer, register the flag in CHECK, hold the result until taken.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            res_id_q    <= '0;
            res_data_q  <= '0;
            res_pal_q   <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (transfer) begin
                        res_id_q   <= grant_idx;
                        res_data_q <= grant_word;
                        rr_ptr_q   <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
                        state_q    <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    res_pal_q   <= check_pal;
                    res_valid_q <= 1'b1;
                    state_q     <= ST_RESULT;
                end
                ST_RESULT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    res_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    // Saturating delivery statistics; clear wins over a same-cycle increment.
    always_ff @(posedge clock) begin
        if (!reset_n || clear_counts) begin
            total_q <= '0;
            pal_q   <= '0;
        end else if (res_hs) begin
            if (total_q != '1) begin
                total_q <= total_q + CNT_W'(1);
            end
            if (res_pal_q && pal_q != '1) begin
                pal_q <= pal_q + CNT_W'(1);
            end
        end
    end

    assign res_valid      = res_valid_q;
    assign res_id         = res_id_q;
    assign res_data       = res_data_q;
    assign res_palindrome = res_pal_q;
    assign total_count    = total_q;
    assign pal_count      = pal_q;

endmodule

// File: tb/tb_pal_check_scheduler.sv
// tb/tb_pal_check_scheduler.sv - directed scoreboard bench for pal_check_scheduler
module tb_pal_check_scheduler;

    localparam int N = 4;
    localparam int W = 8;
    localparam int C = 4;

    typedef struct {
        int         id;
        logic [7:0] data;
        logic       pal;
    } exp_t;

    logic             clock;
    logic             reset_n;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_ready;
    logic             res_valid;
    logic             res_ready;
    logic [1:0]       res_id;
    logic [W-1:0]     res_data;
    logic             res_palindrome;
    logic             clear_counts;
    logic [C-1:0]     total_count;
    logic [C-1:0]     pal_count;

    pal_check_scheduler #(.N_REQ(N), .WIDTH(W), .CNT_W(C)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_id         (res_id),
        .res_data       (res_data),
        .res_palindrome (res_palindrome),
        .clear_counts   (clear_counts),
        .total_count    (total_count),
        .pal_count      (pal_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t q[$];
    int   m_state, m_rr, m_total, m_pal;
    logic seen_valid;
    int   obs_id, obs_cyc, obs_pal, obs_data, obs_rdy;
    logic dut_granted;
    int   dut_gid, dut_gcyc;
    int   g_id[$];
    int   g_cyc[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic is_pal(input logic [7:0] d);
        for (int k = 0; k < 4; k++) if (d[k] != d[7-k]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int winner(input logic [N-1:0] v, input int rr);
        for (int k = 0; k < N; k++) if (v[(rr + k) % N]) return (rr + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_state = 0; m_rr = 0; m_total = 0; m_pal = 0;
        q.delete();
    endtask

    // One clock: settle, compare against the scoreboard/model, advance the model, cross the edge.
    task automatic cycle();
        logic [N-1:0] exp_rdy;
        int w;
        exp_t e;
        #1;
        w = winner(req_valid, m_rr);
        exp_rdy = '0;
        if (m_state == 0 && w >= 0) exp_rdy[w] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("res_valid", 32'(res_valid), 32'(m_state == 2));
        if (m_state == 2 && q.size() > 0) begin
            check("res_id", 32'(res_id), 32'(q[0].id));
            check("res_data", 32'(res_data), 32'(q[0].data));
            check("res_palindrome", 32'(res_palindrome), 32'(q[0].pal));
        end
        check("total_count", 32'(total_count), 32'(m_total));
        check("pal_count", 32'(pal_count), 32'(m_pal));
        seen_valid = res_valid;
        obs_id = int'(res_id); obs_data = int'(res_data); obs_pal = int'(res_palindrome);
        obs_cyc = cyc; obs_rdy = int'(req_ready);
        dut_granted = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                dut_granted = 1'b1; dut_gid = i; dut_gcyc = cyc;
                g_id.push_back(i); g_cyc.push_back(cyc);
            end
        end
        if (!reset_n) begin
            model_reset();
        end else begin
            if (m_state == 2) begin
                if (res_ready) begin
                    e = q.pop_front();
                    if (m_total != 15) m_total++;
                    if (e.pal && m_pal != 15) m_pal++;
                    m_state = 0;
                end
            end else if (m_state == 1) begin
                m_state = 2;
            end else if (w >= 0) begin
                e.id = w; e.data = req_data[w*W +: W]; e.pal = is_pal(e.data);
                q.push_back(e);
                m_rr = (w + 1) % N;
                m_state = 1;
            end
            if (clear_counts) begin
                m_total = 0; m_pal = 0;
            end
        end
        @(posedge clock);
        cyc++;
        #1;
    endtask

    task automatic wait_result();
        logic found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            cycle();
            if (seen_valid) found = 1'b1;
        end
        check("result_timeout", 32'(found), 32'd1);
    endtask

    task automatic drain();
        req_valid = '0;
        res_ready = 1'b1;
        for (int i = 0; i < 12 && m_state != 0; i++) cycle();
        check("drain_timeout", 32'(m_state), 32'd0);
    endtask

    task automatic send(input int id, input logic [7:0] d);
        req_valid = '0;
        req_valid[id] = 1'b1;
        req_data[id*W +: W] = d;
        cycle();
        check("grant_taken", 32'(dut_granted), 32'd1);
        req_valid = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req_valid = '0;
        cycle();
        reset_n = 1'b1;
    endtask

    initial begin
        int t0;
        int b_id, b_data, b_pal, tot0;
        reset_n = 1'b0; req_valid = '0; req_data = '0; res_ready = 1'b1; clear_counts = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        model_reset();
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_total", 32'(total_count), 32'd0);
        check("rst_pal", 32'(pal_count), 32'd0);
        check("rst_res_id", 32'(res_id), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);

        // Single palindromic request from requester 2
        send(2, 8'b1001_1001);
        t0 = dut_gcyc;
        wait_result();
        check("single_latency", 32'(obs_cyc - t0), 32'd2);
        check("single_id", 32'(obs_id), 32'd2);
        check("single_pal", 32'(obs_pal), 32'd1);
        cycle();
        check("single_total", 32'(total_count), 32'd1);
        check("single_palcnt", 32'(pal_count), 32'd1);

        // Non-palindrome from requester 3
        send(3, 8'b1101_1010);
        wait_result();
        check("nonpal_flag", 32'(obs_pal), 32'd0);
        cycle();
        check("nonpal_total", 32'(total_count), 32'd2);
        check("nonpal_palcnt", 32'(pal_count), 32'd1);

        // Fairness with all requesters valid from reset
        do_reset();
        g_id.delete(); g_cyc.delete();
        req_data = {8'hF0, 8'h12, 8'h3C, 8'h81};
        req_valid = 4'hF;
        for (int i = 0; i < 40 && g_id.size() < 5; i++) cycle();
        check("fair_grants", 32'(g_id.size()), 32'd5);
        if (g_id.size() == 5) begin
            for (int i = 0; i < 5; i++) check("fair_order", 32'(g_id[i]), 32'(i % 4));
            for (int i = 1; i < 5; i++) check("fair_spacing", 32'(g_cyc[i] - g_cyc[i-1]), 32'd3);
        end
        drain();

        // Backpressure on requester 1 while requester 3 waits
        send(1, 8'h5A);
        req_valid = 4'b1000;
        req_data[3*W +: W] = 8'hE7;
        res_ready = 1'b0;
        wait_result();
        b_id = obs_id; b_data = obs_data; b_pal = obs_pal;
        check("bp_id", 32'(b_id), 32'd1);
        tot0 = int'(total_count);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("bp_stable_id", 32'(obs_id), 32'(b_id));
            check("bp_stable_data", 32'(obs_data), 32'(b_data));
            check("bp_stable_pal", 32'(obs_pal), 32'(b_pal));
            check("bp_no_ready", 32'(obs_rdy), 32'd0);
        end
        res_ready = 1'b1;
        cycle();
        cycle();
        check("bp_count_once", 32'(total_count), 32'(tot0 + 1));
        drain();

        // Saturation and clear with a 4-bit counter
        do_reset();
        for (int n = 0; n < 17; n++) begin
            send(0, 8'hFF);
            wait_result();
        end
        cycle();
        check("sat_total", 32'(total_count), 32'd15);
        check("sat_pal", 32'(pal_count), 32'd15);
        send(0, 8'hFF);
        cycle();
        clear_counts = 1'b1;
        cycle();
        check("clr_hs_valid", 32'(seen_valid), 32'd1);
        clear_counts = 1'b0;
        cycle();
        check("clr_total", 32'(total_count), 32'd0);
        check("clr_pal", 32'(pal_count), 32'd0);

        // Dropping valid in the grant cycle cancels and leaves rr_ptr alone
        req_valid = 4'b0100;
        req_data[2*W +: W] = 8'h18;
        #1;
        check("drop_offer", 32'(req_ready), 32'h4);
        req_valid = '0;
        cycle();
        check("drop_no_xfer", 32'(dut_granted), 32'd0);
        req_valid = 4'b1100;
        req_data[3*W +: W] = 8'h01;
        cycle();
        check("drop_rr_kept", 32'(dut_gid), 32'd2);
        drain();

        // Reset while in CHECK
        send(2, 8'h66);
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        check("mid_rst_valid", 32'(res_valid), 32'd0);
        check("mid_rst_total", 32'(total_count), 32'd0);
        check("mid_rst_pal", 32'(pal_count), 32'd0);
        req_valid = 4'hF;
        cycle();
        check("mid_rst_grant", 32'(obs_rdy), 32'h1);
        drain();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
